// File: rtl/fifo_burst_reader_if.sv
// FIFO read port plus outbound valid/ready stream for the burst reader.
// The master modport is the reader, the slave modport is the FIFO/consumer.
interface fifo_burst_reader_if #(
   parameter int WIDTH = 16
);
   logic             fifo_read_en;
   logic [WIDTH-1:0] fifo_read_data;
   logic             fifo_empty;
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_data;

   modport master (
      output fifo_read_en,
      output m_valid,
      output m_data,
      input  fifo_read_data,
      input  fifo_empty,
      input  m_ready
   );

   modport slave (
      input  fifo_read_en,
      input  m_valid,
      input  m_data,
      output fifo_read_data,
      output fifo_empty,
      output m_ready
   );
endinterface

// File: rtl/fifo_burst_reader.sv
// Pops a burst of len words from a 1-cycle-latency FIFO and forwards
// them in order through a 2-entry buffer onto a valid/ready stream.
module fifo_burst_reader #(
   parameter int WIDTH = 16,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   output logic             done,
   fifo_burst_reader_if.master bus
);

   typedef enum logic [1:0] {
      IDLE,
      XFER,
      DRAIN,
      DONE
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [LEN_W-1:0] issue_left;
   logic [LEN_W-1:0] send_left;
   logic             rd_pending;
   logic [1:0]       buf_count;
   logic [WIDTH-1:0] head_q;
   logic [WIDTH-1:0] tail_q;
   logic             pop;
   logic             push;
   logic             rd_en;
   logic             last_send;
   logic [2:0]       occ;

   assign pop  = bus.m_valid && bus.m_ready;
   assign push = rd_pending;
   assign occ  = {1'b0, buf_count} + {2'b00, rd_pending};

   // A word leaving downstream this cycle frees a slot for a new pop.
   assign rd_en = rstN
               && (state_q == XFER)
               && (issue_left != '0)
               && !bus.fifo_empty
               && (occ < (3'd2 + {2'b00, pop}));

   assign last_send = pop && (send_left == LEN_W'(1));

   assign bus.fifo_read_en = rd_en;
   assign bus.m_valid      = (buf_count != 2'd0);
   assign bus.m_data       = head_q;
   assign busy = (state_q == XFER) || (state_q == DRAIN);
   assign done = (state_q == DONE);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = (len != '0) ? XFER : DONE;
            end
         end
         XFER: begin
            if (last_send) begin
               state_d = DONE;
            end else if (issue_left == '0) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (last_send) begin
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstN) begin
         state_q    <= IDLE;
         issue_left <= '0;
         send_left  <= '0;
         rd_pending <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_pending <= rd_en;
         if ((state_q == IDLE) && start) begin
            issue_left <= len;
            send_left  <= len;
         end else begin
            if (rd_en) begin
               issue_left <= issue_left - LEN_W'(1);
            end
            if (pop && (send_left != '0)) begin
               send_left <= send_left - LEN_W'(1);
            end
         end
      end
   end

   // Head is the stream word; tail only holds the second queued word.
   always_ff @(posedge clk) begin
      if (!rstN) begin
         buf_count <= 2'd0;
         head_q    <= '0;
         tail_q    <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (buf_count == 2'd0) begin
                  head_q    <= bus.fifo_read_data;
                  buf_count <= 2'd1;
               end else if (buf_count == 2'd1) begin
                  tail_q    <= bus.fifo_read_data;
                  buf_count <= 2'd2;
               end
            end
            2'b01: begin
               if (buf_count == 2'd2) begin
                  head_q <= tail_q;
               end
               buf_count <= buf_count - 2'd1;
            end
            2'b11: begin
               if (buf_count == 2'd2) begin
                  head_q <= tail_q;
                  tail_q <= bus.fifo_read_data;
               end else begin
                  head_q <= bus.fifo_read_data;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: queue-based FIFO model, stream scoreboard
// and per-scenario tasks.
module tb_fifo_burst_reader;

   typedef logic [15:0] word_t;

   logic       clk = 1'b0;
   logic       rstN = 1'b0;
   logic       start = 1'b0;
   logic [7:0] len = 8'd0;
   logic       busy;
   logic       done;

   fifo_burst_reader_if #(.WIDTH(16)) bus ();

   fifo_burst_reader #(
      .WIDTH(16),
      .LEN_W(8)
   ) dut (
      .clk  (clk),
      .rstN (rstN),
      .start(start),
      .len  (len),
      .busy (busy),
      .done (done),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int    tests_run = 0;
   int    fails = 0;
   word_t fq[$];
   word_t got_q[$];
   word_t exp_q[$];
   int    cyc = 0;
   int    en_cnt, first_en, last_en;
   int    first_hs, last_hs;
   int    done_cnt, done_cyc;
   int    busy_cnt, busy_bad;
   int    stall_viol, overflow, pop_empty;
   int    occ = 0;
   bit    prev_stall = 1'b0;
   word_t prev_data = '0;

   // FIFO model and stream monitor; every edge, records what happened.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         if (!rstN) begin
            prev_stall = 1'b0;
            occ = 0;
         end else begin
            if (bus.fifo_read_en) begin
               en_cnt++;
               if (en_cnt == 1) first_en = cyc;
               last_en = cyc;
               if (fq.size() == 0) begin
                  pop_empty++;
               end else begin
                  bus.fifo_read_data <= fq.pop_front();
                  bus.fifo_empty <= (fq.size() == 0);
               end
            end
            if (prev_stall && (!bus.m_valid || bus.m_data !== prev_data))
               stall_viol++;
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data = bus.m_data;
            if (bus.m_valid && bus.m_ready) begin
               got_q.push_back(bus.m_data);
               if (got_q.size() == 1) first_hs = cyc;
               last_hs = cyc;
            end
            occ = occ + int'(bus.fifo_read_en)
                - int'(bus.m_valid && bus.m_ready);
            if (occ > 2) overflow++;
            if (done) begin
               done_cnt++;
               done_cyc = cyc;
               if (busy) busy_bad++;
            end
            if (busy) busy_cnt++;
         end
      end
   end

   function automatic bit q_eq(input word_t a[$], input word_t b[$]);
      if (a.size() != b.size()) return 1'b0;
      foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic word_t q_first(input word_t a[$]);
      return (a.size() == 0) ? 16'hxxxx : a[0];
   endfunction

   task automatic clear_logs();
      got_q.delete();
      exp_q.delete();
      en_cnt = 0; first_en = 0; last_en = 0;
      first_hs = 0; last_hs = 0;
      done_cnt = 0; done_cyc = 0;
      busy_cnt = 0; busy_bad = 0;
      stall_viol = 0; overflow = 0; pop_empty = 0;
   endtask

   task automatic push_word(input word_t w);
      fq.push_back(w);
      bus.fifo_empty <= 1'b0;
   endtask

   task automatic flush_fifo();
      fq.delete();
      bus.fifo_empty <= 1'b1;
   endtask

   task automatic start_cmd(input int n, output int c0);
      start = 1'b1;
      len = 8'(n);
      @(posedge clk);
      #1;
      c0 = cyc;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(posedge clk);
         #1;
         if (done_cnt != 0) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      rstN = 1'b0;
      bus.m_ready = 1'b0;
      bus.fifo_read_data <= '0;
      bus.fifo_empty <= 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (bus.fifo_read_en !== 1'b0) begin
         fails++; $display("FAIL rst_rd_en got %b want 0", bus.fifo_read_en);
      end
      tests_run++;
      if (busy !== 1'b0) begin
         fails++; $display("FAIL rst_busy got %b want 0", busy);
      end
      tests_run++;
      if (done !== 1'b0) begin
         fails++; $display("FAIL rst_done got %b want 0", done);
      end
      tests_run++;
      if (bus.m_valid !== 1'b0) begin
         fails++; $display("FAIL rst_valid got %b want 0", bus.m_valid);
      end
      tests_run++;
      if (bus.m_data !== 16'h0) begin
         fails++; $display("FAIL rst_data got %h want 0000", bus.m_data);
      end
      @(posedge clk);
      #1;
      rstN = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      int c0;
      bit ok;
      clear_logs();
      push_word(16'h1111); push_word(16'h2222); push_word(16'h3333);
      exp_q = '{16'h1111, 16'h2222, 16'h3333};
      bus.m_ready = 1'b1;
      start_cmd(3, c0);
      wait_done(50, ok);
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if (!ok) begin fails++; $display("FAIL basic_timeout got no done want done"); end
      tests_run++;
      if (en_cnt != 3) begin fails++; $display("FAIL basic_pops got %0d want 3", en_cnt); end
      tests_run++;
      if (first_en != c0 + 1 || last_en != c0 + 3) begin
         fails++;
         $display("FAIL basic_pop_cycles got %0d..%0d want %0d..%0d",
                  first_en, last_en, c0 + 1, c0 + 3);
      end
      tests_run++;
      if (!q_eq(got_q, exp_q)) begin
         fails++;
         $display("FAIL basic_data got n=%0d first=%h want n=3 first=1111",
                  got_q.size(), q_first(got_q));
      end
      tests_run++;
      if (first_hs != c0 + 3) begin
         fails++; $display("FAIL basic_latency got %0d want %0d", first_hs, c0 + 3);
      end
      tests_run++;
      if (done_cnt != 1 || done_cyc != last_hs + 1) begin
         fails++;
         $display("FAIL basic_done got cnt=%0d cyc=%0d want cnt=1 cyc=%0d",
                  done_cnt, done_cyc, last_hs + 1);
      end
      tests_run++;
      if (busy_bad != 0) begin fails++; $display("FAIL basic_busy_at_done got %0d want 0", busy_bad); end
   endtask

   task automatic test_len0();
      int c0;
      clear_logs();
      push_word(16'hbeef);
      bus.m_ready = 1'b1;
      start_cmd(0, c0);
      repeat (4) @(posedge clk);
      #1;
      tests_run++;
      if (en_cnt != 0) begin fails++; $display("FAIL len0_pops got %0d want 0", en_cnt); end
      tests_run++;
      if (busy_cnt != 0) begin fails++; $display("FAIL len0_busy got %0d cycles want 0", busy_cnt); end
      tests_run++;
      if (done_cnt != 1 || done_cyc != c0 + 1) begin
         fails++;
         $display("FAIL len0_done got cnt=%0d cyc=%0d want cnt=1 cyc=%0d",
                  done_cnt, done_cyc, c0 + 1);
      end
      flush_fifo();
   endtask

   task automatic test_stall();
      int    c0;
      bit    ok;
      bit [5:0] pat;
      word_t w;
      pat = 6'b101001;
      clear_logs();
      for (int i = 0; i < 8; i++) begin
         w = word_t'($urandom);
         push_word(w);
         exp_q.push_back(w);
      end
      bus.m_ready = 1'b1;
      start_cmd(8, c0);
      ok = 1'b0;
      for (int k = 0; k < 200 && !ok; k++) begin
         bus.m_ready = pat[k % 6];
         @(posedge clk);
         #1;
         if (done_cnt != 0) ok = 1'b1;
      end
      bus.m_ready = 1'b1;
      tests_run++;
      if (!ok) begin fails++; $display("FAIL stall_timeout got no done want done"); end
      tests_run++;
      if (!q_eq(got_q, exp_q)) begin
         fails++;
         $display("FAIL stall_data got n=%0d first=%h want n=8 first=%h",
                  got_q.size(), q_first(got_q), exp_q[0]);
      end
      tests_run++;
      if (stall_viol != 0) begin fails++; $display("FAIL stall_hold got %0d changes want 0", stall_viol); end
      tests_run++;
      if (overflow != 0) begin fails++; $display("FAIL stall_overflow got %0d want 0", overflow); end
      tests_run++;
      if (en_cnt != 8 || done_cnt != 1) begin
         fails++; $display("FAIL stall_counts got pops=%0d done=%0d want 8/1", en_cnt, done_cnt);
      end
   endtask

   task automatic test_empty_start();
      int c0;
      bit ok;
      clear_logs();
      flush_fifo();
      bus.m_ready = 1'b1;
      start_cmd(2, c0);
      repeat (5) @(posedge clk);
      #1;
      push_word(16'h0a0a); push_word(16'h0b0b);
      exp_q = '{16'h0a0a, 16'h0b0b};
      wait_done(40, ok);
      tests_run++;
      if (!ok) begin fails++; $display("FAIL empty_timeout got no done want done"); end
      tests_run++;
      if (pop_empty != 0) begin fails++; $display("FAIL empty_pop got %0d want 0", pop_empty); end
      tests_run++;
      if (!q_eq(got_q, exp_q)) begin
         fails++;
         $display("FAIL empty_data got n=%0d first=%h want n=2 first=0a0a",
                  got_q.size(), q_first(got_q));
      end
      tests_run++;
      if (done_cyc != last_hs + 1) begin
         fails++; $display("FAIL empty_done got %0d want %0d", done_cyc, last_hs + 1);
      end
   endtask

   task automatic test_reset_mid();
      int c0;
      bit ok;
      clear_logs();
      for (int i = 0; i < 8; i++) push_word(word_t'(16'h5000 + i));
      bus.m_ready = 1'b1;
      start_cmd(5, c0);
      ok = 1'b0;
      for (int i = 0; i < 30 && !ok; i++) begin
         @(posedge clk);
         #1;
         ok = (got_q.size() >= 2);
      end
      tests_run++;
      if (!ok) begin fails++; $display("FAIL rmid_progress got %0d words want 2", got_q.size()); end
      rstN = 1'b0;
      @(posedge clk);
      #1;
      rstN = 1'b1;
      tests_run++;
      if (bus.m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL rmid_state got v=%b b=%b d=%b want 0/0/0",
                  bus.m_valid, busy, done);
      end
      repeat (4) @(posedge clk);
      #1;
      tests_run++;
      if (done_cnt != 0 || en_cnt > 5) begin
         fails++; $display("FAIL rmid_abort got done=%0d pops=%0d want 0/<=5", done_cnt, en_cnt);
      end
      clear_logs();
      for (int i = 0; i < 3 && i < fq.size(); i++) exp_q.push_back(fq[i]);
      start_cmd(3, c0);
      wait_done(40, ok);
      tests_run++;
      if (!ok || !q_eq(got_q, exp_q)) begin
         fails++;
         $display("FAIL rmid_restart got n=%0d first=%h want n=%0d first=%h",
                  got_q.size(), q_first(got_q), exp_q.size(), q_first(exp_q));
      end
      flush_fifo();
   endtask

   task automatic test_start_ignored();
      int c0;
      bit ok;
      clear_logs();
      for (int i = 0; i < 6; i++) begin
         push_word(word_t'(16'h7700 + i));
         if (i < 4) exp_q.push_back(word_t'(16'h7700 + i));
      end
      bus.m_ready = 1'b1;
      start_cmd(4, c0);
      start = 1'b1;
      len = 8'd1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(40, ok);
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if (!ok || !q_eq(got_q, exp_q)) begin
         fails++;
         $display("FAIL ignore_data got n=%0d want n=4", got_q.size());
      end
      tests_run++;
      if (en_cnt != 4 || done_cnt != 1) begin
         fails++; $display("FAIL ignore_counts got pops=%0d done=%0d want 4/1", en_cnt, done_cnt);
      end
      flush_fifo();
   endtask

   task automatic test_max_len();
      int    c0;
      bit    ok;
      word_t w;
      clear_logs();
      for (int i = 0; i < 255; i++) begin
         w = word_t'($urandom);
         push_word(w);
         exp_q.push_back(w);
      end
      bus.m_ready = 1'b1;
      start_cmd(255, c0);
      wait_done(400, ok);
      tests_run++;
      if (!ok || !q_eq(got_q, exp_q) || en_cnt != 255) begin
         fails++;
         $display("FAIL maxlen got n=%0d pops=%0d want 255/255", got_q.size(), en_cnt);
      end
   endtask

   task automatic test_random();
      int    c0, n, pushed;
      bit    ok;
      word_t w[$];
      for (int it = 0; it < 15; it++) begin
         clear_logs();
         flush_fifo();
         w.delete();
         n = $urandom_range(1, 12);
         for (int i = 0; i < n + 2; i++) w.push_back(word_t'($urandom));
         for (int i = 0; i < n; i++) exp_q.push_back(w[i]);
         pushed = $urandom_range(0, n);
         for (int i = 0; i < pushed; i++) push_word(w[i]);
         bus.m_ready = ($urandom % 4) != 0;
         start_cmd(n, c0);
         ok = 1'b0;
         for (int k = 0; k < 400 && !ok; k++) begin
            bus.m_ready = ($urandom % 4) != 0;
            if (pushed < n + 2 && ($urandom % 2) == 1) begin
               push_word(w[pushed]);
               pushed++;
            end
            @(posedge clk);
            #1;
            if (done_cnt != 0) ok = 1'b1;
         end
         tests_run++;
         if (!ok || !q_eq(got_q, exp_q)) begin
            fails++;
            $display("FAIL rand%0d_data got n=%0d first=%h want n=%0d first=%h",
                     it, got_q.size(), q_first(got_q), n, exp_q[0]);
         end
         tests_run++;
         if (overflow != 0 || stall_viol != 0 || pop_empty != 0) begin
            fails++;
            $display("FAIL rand%0d_rules got ovf=%0d hold=%0d empty=%0d want 0/0/0",
                     it, overflow, stall_viol, pop_empty);
         end
         tests_run++;
         if (done_cnt != 1 || en_cnt != n) begin
            fails++;
            $display("FAIL rand%0d_counts got done=%0d pops=%0d want 1/%0d",
                     it, done_cnt, en_cnt, n);
         end
      end
      flush_fifo();
   endtask

   initial begin
      clear_logs();
      bus.m_ready = 1'b0;
      test_reset();
      test_basic();
      test_len0();
      test_stall();
      test_empty_start();
      test_reset_mid();
      test_start_ignored();
      test_max_len();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
